rr_grant_arbiter: RTL

RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

---
 rtl/rr_arb_pkg.sv | 10 +
 rtl/lsb_isolate.sv | 25 ++
 rtl/rr_grant_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types for the round-robin grant arbiter.
//   state_t : arbiter FSM state (IDLE = no grant offered, GRANT = grant offered)
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/lsb_isolate.sv
// Isolates the lowest set bit of a vector (purely combinational).
// Ports:
//   vec_i : input vector
//   lsb_o : one-hot vector with only the lowest set bit of vec_i, or zero
module lsb_isolate #(
  parameter int ARRAYSIZE = 4
) (
  input  logic [ARRAYSIZE-1:0] vec_i,
  output logic [ARRAYSIZE-1:0] lsb_o
);

  logic seen;

  always_comb begin
    lsb_o = '0;
    seen  = 1'b0;
    for (int i = 0; i < ARRAYSIZE; i++) begin
      if (vec_i[i] && !seen) begin
        lsb_o[i] = 1'b1;
        seen     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with a registered one-hot grant and a
// valid/ready hand-off to the consumer.
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   req        : request vector, bit i = requester i wants service
//   gnt        : registered one-hot grant, zero while gnt_valid = 0
//   gnt_idx    : binary index of the granted requester, zero while gnt_valid = 0
//   gnt_valid  : a grant is being offered
//   gnt_ready  : consumer accepts the offered grant
//   dbg_state  : current FSM state
//   dbg_mask   : current priority mask
//
// Handshake: a grant transfers on a rising edge where gnt_valid and gnt_ready
// are both 1. While gnt_valid = 1 and gnt_ready = 0 the grant (gnt, gnt_idx)
// is held unchanged regardless of req. gnt_ready while gnt_valid = 0 has no
// effect.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter int ARRAYSIZE = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ARRAYSIZE-1:0]         req,
  output logic [ARRAYSIZE-1:0]         gnt,
  output logic [$clog2(ARRAYSIZE)-1:0] gnt_idx,
  output logic                         gnt_valid,
  input  logic                         gnt_ready,
  output state_t                       dbg_state,
  output logic [ARRAYSIZE-1:0]         dbg_mask
);

  localparam int IDXW = $clog2(ARRAYSIZE);

  state_t               state_q, state_d;
  logic [ARRAYSIZE-1:0] gnt_q, gnt_d;
  logic [ARRAYSIZE-1:0] mask_q, mask_d;

  logic [IDXW-1:0]      idx;
  logic                 handshake;
  logic [ARRAYSIZE-1:0] mask_upd;
  logic [ARRAYSIZE-1:0] mask_sel;
  logic [ARRAYSIZE-1:0] req_masked;
  logic [ARRAYSIZE-1:0] masked_lsb;
  logic [ARRAYSIZE-1:0] plain_lsb;
  logic [ARRAYSIZE-1:0] cand;

  // Index decoded from the registered grant, so it is glitch-free and
  // naturally zero when no grant is held.
  always_comb begin
    idx = '0;
    for (int i = 0; i < ARRAYSIZE; i++) begin
      if (gnt_q[i]) idx = idx | IDXW'(i);
    end
  end

  assign handshake = (state_q == GRANT) && gnt_ready;

  // Priority after serving index idx: only requesters above it, wrapping to
  // everyone once the top requester has been served.
  always_comb begin
    mask_upd = '0;
    for (int i = 0; i < ARRAYSIZE; i++) begin
      if (i > int'(idx)) mask_upd[i] = 1'b1;
    end
    if (int'(idx) == ARRAYSIZE - 1) mask_upd = '1;
  end

  // On a handshake the follow-on grant is chosen with the already-updated
  // mask so back-to-back grants need no bubble cycle.
  assign mask_sel   = handshake ? mask_upd : mask_q;
  assign req_masked = req & mask_sel;

  lsb_isolate #(.ARRAYSIZE(ARRAYSIZE)) u_lsb_masked (
    .vec_i (req_masked),
    .lsb_o (masked_lsb)
  );

  lsb_isolate #(.ARRAYSIZE(ARRAYSIZE)) u_lsb_plain (
    .vec_i (req),
    .lsb_o (plain_lsb)
  );

  assign cand = (|req_masked) ? masked_lsb : plain_lsb;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = cand;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          mask_d = mask_upd;
          if (|req) begin
            gnt_d = cand;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      mask_q  <= '1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      mask_q  <= mask_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx;
  assign gnt_valid = (state_q == GRANT);
  assign dbg_state = state_q;
  assign dbg_mask  = mask_q;

endmodule
